// File: rtl/sigmoid_sequencer.sv
// ----------------------------------------------------------------------------
// sigmoid_sequencer
//   Job controller for one stochastic sigmoid neuron. A W-bit operand is
//   encoded as a unipolar bitstream (x_bit_o = lfsr < operand). The controller
//   holds the neuron datapath in reset for CLR cycles, streams WARM warm-up
//   cycles that are not counted, then counts sig_y_i ones over 2^LEN_LOG2
//   cycles. The count is scaled to a W-bit result and held until accepted.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid_i   operand valid
//   in_ready_o   high only in IDLE
//   operand_i    W-bit job operand, captured on in_valid_i & in_ready_o
//   x_bit_o      input bitstream to the neuron
//   sig_n_rst_o  active-low neuron datapath reset (high in WARMUP/COUNT)
//   sig_y_i      neuron output bitstream (sampled in COUNT only)
//   out_valid_o  result valid
//   out_ready_i  result accepted on out_valid_o & out_ready_i
//   result_o     scaled ones count
//   busy_o       controller not idle
//
// Configuration macro
//   SIGSEQ_LFSR_RESEED_EN  reload the LFSR with SEED whenever a job is
//                          accepted; otherwise the LFSR free-runs from reset.
// ----------------------------------------------------------------------------
module sigmoid_sequencer #(
   parameter int           W        = 8,
   parameter int           LEN_LOG2 = 8,
   parameter int           CLR      = 2,
   parameter int           WARM     = 16,
   parameter logic [W-1:0] SEED     = 8'h5A,
   parameter logic [W-1:0] TAPS     = 8'hB8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] operand_i,
   output logic         x_bit_o,
   output logic         sig_n_rst_o,
   input  logic         sig_y_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] result_o,
   output logic         busy_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_WARMUP = 3'd2;
   localparam logic [2:0] S_COUNT  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   // One phase counter is shared by CLEAR, WARMUP and COUNT; size it for
   // the longest of the three.
   localparam int CW0 = (LEN_LOG2 > $clog2(CLR + 1)) ? LEN_LOG2 : $clog2(CLR + 1);
   localparam int CW  = ((CW0 > $clog2(WARM + 1)) ? CW0 : $clog2(WARM + 1)) + 1;
   localparam int OW  = LEN_LOG2 + 1;

   localparam logic [CW-1:0] CLR_LAST  = CW'(CLR - 1);
   localparam logic [CW-1:0] WARM_LAST = CW'((WARM > 0) ? WARM - 1 : 0);
   localparam logic [CW-1:0] LEN_LAST  = CW'((2 ** LEN_LOG2) - 1);
   localparam logic [OW-1:0] ONES_FULL = {1'b1, {LEN_LOG2{1'b0}}};

   logic [2:0]    state_q, state_d;
   logic [W-1:0]  lfsr_q, lfsr_d;
   logic [W-1:0]  opnd_q, opnd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [OW-1:0] ones_q, ones_d;
   logic [W-1:0]  result_q, result_d;
   logic          ovld_q, ovld_d;
   logic [W-1:0]  scaled;
   logic          streaming;

   // A full window of ones would wrap after truncation, so it saturates.
   assign scaled = (ones_q == ONES_FULL) ? {W{1'b1}} : W'(ones_q >> (LEN_LOG2 - W));

   always_comb begin
      state_d  = state_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      ones_d   = ones_q;
      result_d = result_q;
      ovld_d   = ovld_q;
      // Galois LFSR, advances every cycle regardless of state
      lfsr_d   = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : {W{1'b0}});
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               state_d = S_CLEAR;
               opnd_d  = operand_i;
               cnt_d   = '0;
               ones_d  = '0;
`ifdef SIGSEQ_LFSR_RESEED_EN
               lfsr_d  = SEED;
`endif
            end
         end
         S_CLEAR: begin
            ones_d = '0;
            if (cnt_q == CLR_LAST) begin
               cnt_d   = '0;
               state_d = (WARM == 0) ? S_COUNT : S_WARMUP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WARMUP: begin
            if (cnt_q == WARM_LAST) begin
               cnt_d   = '0;
               state_d = S_COUNT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_COUNT: begin
            ones_d = ones_q + OW'(sig_y_i);
            if (cnt_q == LEN_LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            // First DONE cycle loads the result from the settled ones count;
            // out_valid is only raised once the result register holds it.
            if (!ovld_q) begin
               ovld_d   = 1'b1;
               result_d = scaled;
            end else if (out_ready_i) begin
               ovld_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         lfsr_q   <= SEED;
         opnd_q   <= '0;
         cnt_q    <= '0;
         ones_q   <= '0;
         result_q <= '0;
         ovld_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         ones_q   <= ones_d;
         result_q <= result_d;
         ovld_q   <= ovld_d;
      end
   end

   assign streaming   = (state_q == S_WARMUP) || (state_q == S_COUNT);
   assign x_bit_o     = streaming && (lfsr_q < opnd_q);
   assign sig_n_rst_o = streaming;
   assign in_ready_o  = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign out_valid_o = ovld_q;
   assign result_o    = result_q;

endmodule

// File: tb/tb_sigmoid_sequencer.sv
module tb_sigmoid_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] operand = 8'h00;
   logic       sy_drv = 1'b0;
   logic       loopback = 1'b0;
   logic       sig_y;
   logic       in_ready, x_bit, sig_n_rst, out_valid, busy;
   logic [7:0] result;

   assign sig_y = loopback ? x_bit : sy_drv;

   sigmoid_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .operand_i   (operand),
      .x_bit_o     (x_bit),
      .sig_n_rst_o (sig_n_rst),
      .sig_y_i     (sig_y),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      string      nm;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         e;
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [7:0]   last_res;
   logic [299:0] trace, trace_a;
   logic         exp_same;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: pops one expectation per accepted result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL result_unexpected: got %02h, expected no result", result);
         end else begin
            e = exp_q.pop_front();
            if ($isunknown(result) || result < e.lo || result > e.hi) begin
               n_bad++;
               $display("FAIL %s: got %02h, expected %02h..%02h", e.nm, result, e.lo, e.hi);
            end
         end
      end
   end

   // mode 0: sig_y=0, 1: sig_y=1, 2: loopback, 3: sig_y=1 in first 128 COUNT cycles
   task automatic run_job(input logic [7:0] op, input int mode, input logic [7:0] lo,
                          input logic [7:0] hi, input int hold, input string nm);
      int n, lows, highs;
      exp_q.push_back('{lo, hi, nm});
      loopback = (mode == 2);
      sy_drv   = (mode == 1);
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      operand  = op;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0; lows = 0; highs = 0; trace = '0;
      // n counts edges after the accepting edge k
      while (!out_valid && n < 400) begin
         if (mode == 3) sy_drv = (n >= 18 && n < 146);
         if (n < 300) trace[n] = x_bit;
         if (n < 2 && !sig_n_rst) lows++;
         if (sig_n_rst) highs++;
         @(posedge clk);
         #1 n++;
      end
      sy_drv = 1'b0;
      chk({nm, "_latency"}, 32'(n), 32'd275);
      chk({nm, "_nrst_low"}, 32'(lows), 32'd2);
      chk({nm, "_nrst_high"}, 32'(highs), 32'd272);
      last_res = result;
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         operand  = 8'hA5;
         @(posedge clk);
         #1;
         chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({nm, "_hold_result"}, 32'(result), 32'(last_res));
         chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
      chk({nm, "_idle_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_idle_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sig_n_rst", 32'(sig_n_rst), 32'd0);
      chk("rst_x_bit", 32'(x_bit), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      run_job(8'h80, 0, 8'h00, 8'h00, 0, "lat_80");
      run_job(8'h00, 1, 8'hFF, 8'hFF, 0, "sat_ones");
      run_job(8'h00, 3, 8'h80, 8'h80, 0, "half_window");
      run_job(8'h00, 2, 8'h00, 8'h00, 0, "lb_00");
      run_job(8'hFF, 2, 8'hFE, 8'hFF, 0, "lb_ff");
      run_job(8'h40, 2, 8'h38, 8'h48, 0, "lb_40");
      run_job(8'h80, 1, 8'hFF, 8'hFF, 50, "backpressure");

      run_job(8'h55, 2, 8'h50, 8'h5A, 0, "lb_55a");
      trace_a = trace;
      run_job(8'h55, 2, 8'h50, 8'h5A, 0, "lb_55b");
`ifdef SIGSEQ_LFSR_RESEED_EN
      exp_same = 1'b1;
`else
      exp_same = 1'b0;
`endif
      chk("trace_repeat", 32'(trace == trace_a), 32'(exp_same));

      // Abort mid-COUNT: no result must appear.
      sy_drv   = 1'b1;
      loopback = 1'b0;
      in_valid = 1'b1;
      operand  = 8'hC0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("abort_pre_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_async_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_sig_n_rst", 32'(sig_n_rst), 32'd0);
      chk("abort_x_bit", 32'(x_bit), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      sy_drv = 1'b0;

      run_job(8'h00, 1, 8'hFF, 8'hFF, 0, "post_rst");
      repeat (2) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
